vga_frame_gen: RTL and testbench

Vertical timing, framebuffer fetch and pixel output stage of the VGA pipeline. Sits directly downstream of the horizontal sync generator and consumes its free-running column count and registered horizontal sync pulse. Derives the line count, vertical sync, active-video window and linear framebuffer read address. Returns registered RGB444 plus sync outputs, latency-aligned to the framebuffer read data.

---
 rtl/vga_frame_gen.sv | 137 +++++++++++++
 tb/tb_vga_frame_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_gen.sv
// vga_frame_gen: vertical timing, linear framebuffer fetch and RGB444/sync output aligned to the
// framebuffer read latency. Defining VGA_TEST_PATTERN_EN adds the test_en colour-bar mode.
module vga_frame_gen #(
   parameter int H_RES         = 1280,
   parameter int H_TOTAL       = 1688,
   parameter int V_RES         = 1024,
   parameter int V_FRONT_PORCH = 1,
   parameter int V_SYNC_PULSE  = 3,
   parameter int V_BACK_PORCH  = 38,
   parameter int RD_LAT        = 2
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef VGA_TEST_PATTERN_EN
   input  logic        test_en,
`endif
   input  logic [10:0] h_count,
   input  logic        h_sync_in,
   input  logic [11:0] pix_data,
   output logic        fb_rd_en,
   output logic [20:0] fb_addr,
   output logic [10:0] v_count,
   output logic        frame_start,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs
);
   localparam int          V_TOTAL  = V_RES + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_ACT    = 11'(H_RES);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] V_ACT    = 11'(V_RES);
   localparam logic [10:0] VS_FIRST = 11'(V_RES + V_FRONT_PORCH);
   localparam logic [10:0] VS_END   = 11'(V_RES + V_FRONT_PORCH + V_SYNC_PULSE);

   logic              line_end_p0, frame_end_p0, act_p0, vs_p0, rd_req_p0;
   logic [10:0]       v_count_q, v_count_d;
   logic [20:0]       addr_cnt_q, addr_cnt_d;
   logic [20:0]       fb_addr_q, fb_addr_d;
   logic              fb_rd_en_q, frame_start_q;
   logic [RD_LAT:0]   act_sr_q;
   logic [RD_LAT+1:0] vs_sr_q;
   logic [RD_LAT:0]   hs_sr_q;
   logic [11:0]       rgb_q, rgb_d;

   // Stage 0: decode the incoming column against the current line
   always_comb begin
      line_end_p0  = (h_count == H_LAST);
      frame_end_p0 = line_end_p0 && (v_count_q == V_LAST);
      act_p0       = (h_count < H_ACT) && (v_count_q < V_ACT);
      vs_p0        = (v_count_q >= VS_FIRST) && (v_count_q < VS_END);
`ifdef VGA_TEST_PATTERN_EN
      rd_req_p0    = act_p0 && !test_en;
`else
      rd_req_p0    = act_p0;
`endif
      v_count_d  = v_count_q;
      addr_cnt_d = addr_cnt_q;
      fb_addr_d  = fb_addr_q;
      if (line_end_p0) begin
         v_count_d = frame_end_p0 ? 11'd0 : v_count_q + 11'd1;
      end
      if (act_p0) begin
         fb_addr_d  = addr_cnt_q;
         addr_cnt_d = addr_cnt_q + 21'd1;
      end
      if (frame_end_p0) begin
         addr_cnt_d = '0;
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   function automatic logic [11:0] colour_bar(input logic [2:0] idx);
      return {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
   endfunction

   // Column bits ride alongside act so the bar index lines up with the RGB load
   logic [2:0] col_sr_q [RD_LAT+1];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= RD_LAT; i++) col_sr_q[i] <= '0;
      end else begin
         col_sr_q[0] <= h_count[10:8];
         for (int i = 1; i <= RD_LAT; i++) col_sr_q[i] <= col_sr_q[i-1];
      end
   end
`endif

   // Output stage: pix_data arrives together with act delayed by RD_LAT+1
   always_comb begin
      rgb_d = '0;
      if (act_sr_q[RD_LAT]) begin
`ifdef VGA_TEST_PATTERN_EN
         rgb_d = test_en ? colour_bar(col_sr_q[RD_LAT]) : pix_data;
`else
         rgb_d = pix_data;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_count_q     <= '0;
         addr_cnt_q    <= '0;
         fb_addr_q     <= '0;
         fb_rd_en_q    <= 1'b0;
         frame_start_q <= 1'b0;
         act_sr_q      <= '0;
         vs_sr_q       <= '0;
         hs_sr_q       <= '0;
         rgb_q         <= '0;
      end else begin
         v_count_q     <= v_count_d;
         addr_cnt_q    <= addr_cnt_d;
         fb_addr_q     <= fb_addr_d;
         fb_rd_en_q    <= rd_req_p0;
         frame_start_q <= frame_end_p0;
         act_sr_q      <= {act_sr_q[RD_LAT-1:0], act_p0};
         vs_sr_q       <= {vs_sr_q[RD_LAT:0], vs_p0};
         // hsync is already one register late upstream, hence one stage shorter
         hs_sr_q       <= {hs_sr_q[RD_LAT-1:0], h_sync_in};
         rgb_q         <= rgb_d;
      end
   end

   assign fb_rd_en    = fb_rd_en_q;
   assign fb_addr     = fb_addr_q;
   assign v_count     = v_count_q;
   assign frame_start = frame_start_q;
   assign vga_r       = rgb_q[11:8];
   assign vga_g       = rgb_q[7:4];
   assign vga_b       = rgb_q[3:0];
   assign vga_hs      = hs_sr_q[RD_LAT];
   assign vga_vs      = vs_sr_q[RD_LAT+1];
endmodule

// File: tb/tb_vga_frame_gen.sv
// Bench for vga_frame_gen on a reduced raster (16/24 columns, 6/11 lines) so whole frames fit
// in a short run; includes a latency-RD_LAT framebuffer model with hashed contents.
module tb_vga_frame_gen;
   localparam int H_RES   = 16;
   localparam int H_TOTAL = 24;
   localparam int V_RES   = 6;
   localparam int VFP     = 1;
   localparam int VSP     = 2;
   localparam int VBP     = 2;
   localparam int RD_LAT  = 2;
   localparam int V_TOTAL = V_RES + VFP + VSP + VBP;
   localparam int LAT     = RD_LAT + 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] h_count = '0;
   logic        h_sync_in = 1'b0;
   logic [11:0] pix_data;
   logic        fb_rd_en;
   logic [20:0] fb_addr;
   logic [10:0] v_count;
   logic        frame_start;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs;
`ifdef VGA_TEST_PATTERN_EN
   logic        test_en = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   int unsigned salt = 0;

   vga_frame_gen #(
      .H_RES(H_RES), .H_TOTAL(H_TOTAL), .V_RES(V_RES), .V_FRONT_PORCH(VFP),
      .V_SYNC_PULSE(VSP), .V_BACK_PORCH(VBP), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef VGA_TEST_PATTERN_EN
      .test_en(test_en),
`endif
      .h_count(h_count), .h_sync_in(h_sync_in), .pix_data(pix_data),
      .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .v_count(v_count), .frame_start(frame_start),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] mem_f(input int unsigned a);
      int unsigned x;
      x = (a + salt) * 32'd2654435761;
      return x[27:16];
   endfunction

   // Framebuffer: data appears RD_LAT clocks after the read strobe; garbage when not read
   logic [11:0] rd_pipe [RD_LAT];
   always @(posedge clk) begin
      rd_pipe[0] <= fb_rd_en ? mem_f(32'(fb_addr)) : 12'($urandom);
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign pix_data = rd_pipe[RD_LAT-1];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " fb_rd_en"}, fb_rd_en, 0);
      chk({tag, " fb_addr"}, fb_addr, 0);
      chk({tag, " v_count"}, v_count, 0);
      chk({tag, " frame_start"}, frame_start, 0);
      chk({tag, " rgb"}, {vga_r, vga_g, vga_b}, 0);
      chk({tag, " vga_hs"}, vga_hs, 0);
      chk({tag, " vga_vs"}, vga_vs, 0);
   endtask

   // Reference model: line index = line ends seen mod V_TOTAL, address = active pixels this frame
   int m_lines, m_cnt, m_addr, n_rd, n_vs;
   logic [11:0] q_rgb[$];
   logic        q_vs[$];
   logic        q_hs[$];

   task automatic model_reset();
      m_lines = 0; m_cnt = 0; m_addr = 0;
      q_rgb.delete(); q_vs.delete(); q_hs.delete();
      for (int i = 0; i < LAT - 1; i++) begin
         q_rgb.push_back(12'h000);
         q_vs.push_back(1'b0);
      end
      for (int i = 0; i < RD_LAT; i++) q_hs.push_back(1'b0);
   endtask

   task automatic step(input int h, input logic hs);
      int   v;
      logic act, fs, line_end;
      v        = m_lines % V_TOTAL;
      act      = (h < H_RES) && (v < V_RES);
      line_end = (h == H_TOTAL - 1);
      fs       = line_end && (v == V_TOTAL - 1);
      if (act) begin
         m_addr = m_cnt;
         m_cnt++;
      end
      q_rgb.push_back(act ? mem_f(m_addr) : 12'h000);
      q_vs.push_back((v >= V_RES + VFP) && (v < V_RES + VFP + VSP));
      q_hs.push_back(hs);
      if (line_end) m_lines++;
      if (fs) m_cnt = 0;
      h_count = 11'(h);
      h_sync_in = hs;
      @(posedge clk); #1;
      chk("fb_rd_en", fb_rd_en, act);
      chk("fb_addr", fb_addr, m_addr);
      chk("v_count", v_count, m_lines % V_TOTAL);
      chk("frame_start", frame_start, fs);
      chk("rgb", {vga_r, vga_g, vga_b}, q_rgb.pop_front());
      chk("vga_vs", vga_vs, q_vs.pop_front());
      chk("vga_hs", vga_hs, q_hs.pop_front());
      n_rd += int'(fb_rd_en);
      n_vs += int'(vga_vs);
   endtask

   task automatic drive(input int h);
      h_count = 11'(h);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      h_count = '0;
      h_sync_in = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // Short pulse between edges: earlier reads are still in flight in the framebuffer
   task automatic mid_reset();
      #2 rst_n = 1'b0;
      #1 chk_zero("midrst");
      #3 rst_n = 1'b1;
      model_reset();
   endtask

   typedef struct {
      int          h;
      logic        rd;
      int          addr;
      int          v;
      logic [11:0] rgb;
   } vec_t;

   vec_t tbl[10];
   int   hh, rst_at;

   initial begin
      salt = $urandom;
      tbl[0] = '{0, 1'b1, 0, 0, 12'h000};
      tbl[1] = '{1, 1'b1, 1, 0, 12'h000};
      tbl[2] = '{2, 1'b1, 2, 0, 12'h000};
      tbl[3] = '{3, 1'b1, 3, 0, mem_f(0)};
      tbl[4] = '{22, 1'b0, 3, 0, mem_f(1)};
      tbl[5] = '{23, 1'b0, 3, 1, mem_f(2)};
      tbl[6] = '{0, 1'b1, 4, 1, mem_f(3)};
      tbl[7] = '{15, 1'b1, 5, 1, 12'h000};
      tbl[8] = '{16, 1'b0, 5, 1, 12'h000};
      tbl[9] = '{23, 1'b0, 5, 2, mem_f(4)};

      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].h);
         chk($sformatf("tbl%0d fb_rd_en", i), fb_rd_en, tbl[i].rd);
         chk($sformatf("tbl%0d fb_addr", i), fb_addr, tbl[i].addr);
         chk($sformatf("tbl%0d v_count", i), v_count, tbl[i].v);
         chk($sformatf("tbl%0d rgb", i), {vga_r, vga_g, vga_b}, tbl[i].rgb);
      end

      // Last column repeatedly: every clock is a line end, so the frame wrap comes quickly
      do_reset();
      for (int i = 1; i < V_TOTAL; i++) begin
         drive(H_TOTAL - 1);
         chk("fast v_count", v_count, i);
         chk("fast frame_start", frame_start, 0);
      end
      drive(H_TOTAL - 1);
      chk("wrap v_count", v_count, 0);
      chk("wrap frame_start", frame_start, 1);
      drive(0);
      chk("post-wrap frame_start", frame_start, 0);
      chk("post-wrap fb_rd_en", fb_rd_en, 1);
      chk("post-wrap fb_addr", fb_addr, 0);

      // Two full sequential frames
      do_reset();
      n_rd = 0; n_vs = 0;
      for (int f = 0; f < 2; f++)
         for (int l = 0; l < V_TOTAL; l++)
            for (int h = 0; h < H_TOTAL; h++) step(h, (h >= 18) && (h < 21));
      chk("frame rd_en count", n_rd, 2 * H_RES * V_RES);
      chk("frame vs count", n_vs, 2 * VSP * H_TOTAL);

      // Reset mid-frame at line 3 column 7, then finish the partial line and two frames
      for (int l = 0; l < 3; l++)
         for (int h = 0; h < H_TOTAL; h++) step(h, (h >= 18) && (h < 21));
      for (int h = 0; h <= 7; h++) step(h, 1'b0);
      mid_reset();
      for (int h = 8; h < H_TOTAL; h++) step(h, (h >= 18) && (h < 21));
      for (int f = 0; f < 2; f++)
         for (int l = 0; l < V_TOTAL; l++)
            for (int h = 0; h < H_TOTAL; h++) step(h, (h >= 18) && (h < 21));

      // Random column jumps and hsync, with one asynchronous reset somewhere inside
      hh = 0;
      rst_at = $urandom_range(100, 2900);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) hh = $urandom_range(0, H_TOTAL - 1);
         else hh = (hh + 1) % H_TOTAL;
         step(hh, 1'($urandom_range(0, 1)));
         if (i == rst_at) mid_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
